// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_pkg                                                    |
// | Description : Shared types and constants for the instruction fetch stage.  |
// |               Holds the fetch FSM state encoding and default widths.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int PERF_W      = 16;

  // IDLE: no request on the bus
  // REQ : request outstanding, returned data is kept
  // DROP: request outstanding after a redirect, returned data is discarded
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_fifo                                                   |
// | Description : Small synchronous FIFO with flush, used to buffer fetched    |
// |               {pc, instruction} pairs. Head is read combinationally.       |
// | Ports       : clk, rst      - clock, asynchronous active-high reset        |
// |               i_flush       - empty the FIFO (beats same-cycle push/pop)   |
// |               i_push/i_wdata- write one entry                              |
// |               i_pop         - drop the head entry                          |
// |               o_rdata       - head entry                                   |
// |               o_count       - number of valid entries                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;

  // A pop on an empty FIFO is ignored so the count can never underflow.
  assign w_do_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (i_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // The fetch FSM only keeps a request open while there is room, so a
  // push into a full FIFO indicates a control bug upstream.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) !(i_push && !i_flush && (r_count == c_DEPTH))
  );

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_unit                                                   |
// | Description : Instruction fetch stage. Issues single-outstanding requests  |
// |               to instruction memory from the current PC, buffers returned  |
// |               instructions with their PCs and presents them to decode.     |
// |               Drives pc_advance to the next-PC logic; flushes on redirect. |
// | Ports       : clk, reset          - clock, asynchronous active-high reset  |
// |               pc, redirect        - from PC register / branch resolution   |
// |               pc_advance          - to next-PC logic (combinational)       |
// |               imem_req/addr/ack/rdata - instruction memory handshake       |
// |               inst_valid/ready/inst/inst_pc - decode interface             |
// |               perf_stall_cycles   - only with FETCH_PERF_EN                |
// | Options     : FETCH_PERF_EN - adds a saturating 16-bit counter of cycles   |
// |               where a request waits for memory.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               redirect,
  output logic               pc_advance,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               inst_valid,
  input  logic               inst_ready,
  output logic [INSTR_W-1:0] inst,
  output logic [ADDR_W-1:0]  inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_stall_cycles
`endif
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_next;
  logic               r_req;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_count_inc;
  logic [ENTRY_W-1:0] w_head;

  assign w_pop       = inst_valid && inst_ready;
  assign w_count_inc = w_count + 1'b1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      // Registered copy of (state != IDLE) so imem_req comes straight from a flop.
      r_req   <= (w_state_next != IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / handshake logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_push       = 1'b0;
    pc_advance   = 1'b0;
    case (r_state)
      IDLE: begin
        // Never issue in a redirect cycle: pc still holds the old stream.
        if (!redirect && (w_count < c_DEPTH)) begin
          w_addr_next  = pc;
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            w_state_next = IDLE;
          end else begin
            w_push      = 1'b1;
            pc_advance  = 1'b1;
            w_addr_next = r_addr + 1'b1;
            // Keep fetching only if the entry just pushed leaves room.
            // With a same-cycle pop the occupancy is unchanged.
            if (w_pop || (w_count_inc < c_DEPTH)) begin
              w_state_next = REQ;
            end else begin
              w_state_next = IDLE;
            end
          end
        end else if (redirect) begin
          w_state_next = DROP;
        end
      end
      DROP: begin
        // Redirects here are already covered by the flush in progress.
        if (imem_ack) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction buffer
  // ---------------------------------------------------------------------------
  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_wdata ({r_addr, imem_rdata}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign inst_valid = (w_count != '0);
  assign inst       = w_head[INSTR_W-1:0];
  assign inst_pc    = w_head[ENTRY_W-1:INSTR_W];

`ifdef FETCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Memory stall counter (saturating)
  // ---------------------------------------------------------------------------
  logic [PERF_W-1:0] r_perf_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_stall <= '0;
    end else if (imem_req && !imem_ack && (r_perf_stall != {PERF_W{1'b1}})) begin
      r_perf_stall <= r_perf_stall + 1'b1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_unit                                                |
// | Description : Self-checking bench for fetch_unit: directed vector table,   |
// |               wrap / reset / stall-counter sequences, and a randomized run |
// |               against a queue-based reference model.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pc = 8'h00;
  logic        redirect = 1'b0;
  logic        pc_advance;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [15:0] inst;
  logic [7:0]  inst_pc;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .ADDR_W  (8),
    .INSTR_W (16),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .redirect   (redirect),
    .pc_advance (pc_advance),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] pc_tgt = 8'h00;
  int         mem_wait = 0;
  int         lat = 1;

  function automatic logic [15:0] instr_of(input logic [7:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Drive this cycle's inputs (low clock phase) and let combinational outputs settle.
  task automatic apply(input logic rd, input logic [7:0] tgt, input logic rdy, input logic ack);
    redirect   = rd;
    pc_tgt     = tgt;
    inst_ready = rdy;
    imem_ack   = ack;
    imem_rdata = ack ? instr_of(imem_addr) : 16'hDEAD;
    #1;
  endtask

  // Upstream PC register plus the clock edge.
  task automatic tick();
    logic [7:0] nxt;
    nxt = redirect ? pc_tgt : (pc_advance ? pc + 8'd1 : pc);
    @(posedge clk);
    #1;
    pc = nxt;
  endtask

  // Latency-programmable memory: ack in the lat-th cycle of a request.
  function automatic logic mem_ack();
    return imem_req && (mem_wait + 1 >= lat);
  endfunction

  task automatic mem_update(input logic ack, input bit rand_lat);
    if (imem_req) begin
      if (ack) begin
        mem_wait = 0;
        if (rand_lat) lat = $urandom_range(1, 3);
      end else begin
        mem_wait++;
      end
    end else begin
      mem_wait = 0;
    end
  endtask

  task automatic do_reset(input logic [7:0] start_pc);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    redirect   = 1'b0;
    imem_ack   = 1'b0;
    inst_ready = 1'b1;
    pc         = start_pc;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    mem_wait = 0;
  endtask

  typedef struct {
    logic       rd;
    logic [7:0] tgt;
    logic       rdy;
    logic       ack;
    logic       e_req;
    logic [7:0] e_addr;
    logic       e_adv;
    logic       e_valid;
    logic [7:0] e_ipc;
  } vec_t;

  function automatic vec_t mkv(input logic rd, input logic [7:0] tgt, input logic rdy,
                               input logic ack, input logic er, input logic [7:0] ea,
                               input logic eadv, input logic ev, input logic [7:0] eipc);
    vec_t v;
    v.rd = rd; v.tgt = tgt; v.rdy = rdy; v.ack = ack;
    v.e_req = er; v.e_addr = ea; v.e_adv = eadv; v.e_valid = ev; v.e_ipc = eipc;
    return v;
  endfunction

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ins;
  } ent_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[17];
    ent_t q[$];
    ent_t e;
    logic m_busy, m_discard, rd, rdy, ack, pop, push, found;
    logic [7:0] m_addr, tgt;
    int acks;

    //        rd  tgt    rdy ack | req addr   adv valid ipc
    tv[0]  = mkv(0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 8'h00);
    tv[1]  = mkv(0, 8'h00, 1, 1,   1, 8'h10, 1, 0, 8'h00);
    tv[2]  = mkv(0, 8'h00, 1, 1,   1, 8'h11, 1, 1, 8'h10);
    tv[3]  = mkv(0, 8'h00, 1, 1,   1, 8'h12, 1, 1, 8'h11);
    tv[4]  = mkv(0, 8'h00, 0, 1,   1, 8'h13, 1, 1, 8'h12);
    tv[5]  = mkv(0, 8'h00, 0, 0,   0, 8'h00, 0, 1, 8'h12);
    tv[6]  = mkv(0, 8'h00, 1, 0,   0, 8'h00, 0, 1, 8'h12);
    tv[7]  = mkv(0, 8'h00, 0, 0,   0, 8'h00, 0, 1, 8'h13);
    tv[8]  = mkv(0, 8'h00, 1, 1,   1, 8'h14, 1, 1, 8'h13);
    tv[9]  = mkv(0, 8'h00, 1, 0,   1, 8'h15, 0, 1, 8'h14);
    tv[10] = mkv(1, 8'h40, 1, 0,   1, 8'h15, 0, 0, 8'h00);
    tv[11] = mkv(0, 8'h00, 1, 1,   1, 8'h15, 0, 0, 8'h00);
    tv[12] = mkv(0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 8'h00);
    tv[13] = mkv(1, 8'h80, 1, 1,   1, 8'h40, 0, 0, 8'h00);
    tv[14] = mkv(0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 8'h00);
    tv[15] = mkv(0, 8'h00, 1, 1,   1, 8'h80, 1, 0, 8'h00);
    tv[16] = mkv(0, 8'h00, 1, 0,   1, 8'h81, 0, 1, 8'h80);

    // ---------------- reset state ----------------
    do_reset(8'h10);
    chk("rst_req",   imem_req,   1'b0);
    chk("rst_addr",  imem_addr,  8'h00);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst",  inst,       16'h0000);
    chk("rst_ipc",   inst_pc,    8'h00);
`ifdef FETCH_PERF_EN
    chk("rst_perf",  perf_stall_cycles, 16'h0000);
`endif

    // ---------------- directed vector table ----------------
    foreach (tv[i]) begin
      apply(tv[i].rd, tv[i].tgt, tv[i].rdy, tv[i].ack);
      chk($sformatf("tv%0d_req", i),   imem_req,   tv[i].e_req);
      chk($sformatf("tv%0d_adv", i),   pc_advance, tv[i].e_adv);
      chk($sformatf("tv%0d_valid", i), inst_valid, tv[i].e_valid);
      if (tv[i].e_req)   chk($sformatf("tv%0d_addr", i), imem_addr, tv[i].e_addr);
      if (tv[i].e_valid) begin
        chk($sformatf("tv%0d_ipc", i),  inst_pc, tv[i].e_ipc);
        chk($sformatf("tv%0d_inst", i), inst,    instr_of(tv[i].e_ipc));
      end
      tick();
    end

    // ---------------- PC wrap ----------------
    do_reset(8'hFF);
    apply(0, 8'h00, 1, 0);
    tick();
    apply(0, 8'h00, 1, 1);
    chk("wrap_addr_ff", imem_addr, 8'hFF);
    chk("wrap_adv",     pc_advance, 1'b1);
    tick();
    apply(0, 8'h00, 1, 0);
    chk("wrap_addr_00", imem_addr, 8'h00);
    chk("wrap_ipc",     inst_pc,   8'hFF);
    chk("wrap_inst",    inst,      instr_of(8'hFF));
    tick();

`ifdef FETCH_PERF_EN
    // ---------------- stall counter: 4 fetches at 3-cycle latency ----------------
    do_reset(8'h20);
    lat  = 3;
    acks = 0;
    for (int c = 0; c < 40 && acks < 4; c++) begin
      ack = mem_ack();
      apply(0, 8'h00, 1, ack);
      if (ack) acks++;
      mem_update(ack, 1'b0);
      tick();
    end
    chk("perf_acks", acks, 4);
    chk("perf_stall_8", perf_stall_cycles, 16'd8);
`endif

    // ---------------- randomized run against reference model ----------------
    do_reset(8'($urandom));
    lat       = $urandom_range(1, 3);
    m_busy    = 1'b0;
    m_discard = 1'b0;
    m_addr    = 8'h00;
    q.delete();
    for (int c = 0; c < 2500; c++) begin
      rd  = ($urandom_range(0, 19) == 0);
      tgt = 8'($urandom_range(0, 15) + 8'hF4);
      rdy = ($urandom_range(0, 9) < 7);
      ack = mem_ack();
      apply(rd, tgt, rdy, ack);

      chk("rnd_req",   imem_req,   m_busy);
      if (m_busy) chk("rnd_addr", imem_addr, m_addr);
      chk("rnd_adv",   pc_advance, m_busy && !m_discard && ack && !rd);
      chk("rnd_valid", inst_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rnd_ipc",  inst_pc, q[0].pc);
        chk("rnd_inst", inst,    q[0].ins);
      end

      // Reference: one request in flight; kept data goes to the queue,
      // a redirect empties the queue and discards whatever is in flight.
      pop  = (q.size() != 0) && rdy;
      push = 1'b0;
      e    = '{pc: 8'h00, ins: 16'h0000};
      if (m_busy) begin
        if (ack) begin
          if (!m_discard && !rd) begin
            push   = 1'b1;
            e.pc   = m_addr;
            e.ins  = instr_of(m_addr);
            m_addr = m_addr + 8'd1;
          end else begin
            m_busy    = 1'b0;
            m_discard = 1'b0;
          end
        end else if (rd) begin
          m_discard = 1'b1;
        end
      end else if (!rd && q.size() < DEPTH) begin
        m_busy = 1'b1;
        m_addr = pc;
      end
      if (rd) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
      end
      if (push && q.size() >= DEPTH) m_busy = 1'b0;

      mem_update(ack, 1'b1);
      tick();
    end

    // ---------------- asynchronous reset with a request outstanding ----------------
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      apply(0, 8'h00, 1, 0);
      if (imem_req) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("midreq_found", found, 1'b1);
    reset = 1'b1;
    #1;
    chk("midreq_req",   imem_req,   1'b0);
    chk("midreq_valid", inst_valid, 1'b0);
    chk("midreq_addr",  imem_addr,  8'h00);
    @(posedge clk);
    #1;
    chk("midreq_req_held", imem_req, 1'b0);
    reset = 1'b0;
    apply(0, 8'h00, 1, 0);
    chk("midreq_adv", pc_advance, 1'b0);
    tick();
    chk("midreq_reissue", imem_req, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
